pcie_tx_arb: RTL and testbench
==============================

PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 SHALL have port sys_clk_125  in  1  125 MHz core user clock; all logic is on this edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port dl_up  in  1  data link up from core; arbitration is enabled only while high.
REQ-004 SHALL have port req  in  2  per-requester TLP request; bit n belongs to requester n.
REQ-005 SHALL have port req_type  in  4  2 bits per requester: 0 = posted, 1 = non-posted, 2 = completion; 3 is reserved and never eligible.
REQ-006 SHALL have port req_dcred  in  18  9 bits per requester: data credits needed (16-byte units); 0 = header-only TLP.
REQ-007 SHALL have port gnt  out  2  one-hot grant; high for the whole transfer.
REQ-008 SHALL have ports usr_data / usr_st / usr_end  in  32 / 2 / 2  per-requester 16-bit TLP stream.
REQ-009 SHALL have ports tx_req_vc0, tx_data_vc0 [16], tx_st_vc0, tx_end_vc0  out, and tx_rdy_vc0  in: the core VC0 TX interface.
REQ-010 SHALL have inputs tx_ca_ph/nph/cplh_vc0 [9] and tx_ca_pd/npd/cpld_vc0 [13]: core available credits.
REQ-011 SHALL have port arb_timeout  out  1  one-cycle pulse on REQ timeout (macro-dependent).
REQ-012 SHALL have parameter TOUT_CYC, default 4096: cycles to wait for tx_rdy_vc0.

Function
REQ-013 SHALL implement FSM IDLE -> CHECK -> REQ -> XFER -> GAP -> IDLE.
REQ-014 SHALL treat requester n as eligible when req[n] = 1, type != 3, header credit >= 1, and data credit >= req_dcred[n].
REQ-015 SHALL treat a credit value with its MSB set as infinite.
REQ-016 SHALL register the winner in IDLE->CHECK; in CHECK it re-evaluates eligibility and returns to IDLE if the winner has become ineligible.
REQ-017 SHALL choose by round robin on a last-granted pointer; when both are eligible, the non-last requester wins.
REQ-018 SHALL allow an ineligible requester to be bypassed by an eligible one (no head-of-line blocking).
REQ-019 SHALL hold tx_req_vc0 = 1 in REQ until the cycle tx_rdy_vc0 = 1 is sampled, then enter XFER with tx_req_vc0 = 0.
REQ-020 SHALL drive gnt[w] = 1 throughout XFER; the requester asserts usr_st in any XFER cycle.
REQ-021 SHALL mux tx_data/st/end_vc0 combinationally from requester w during XFER (zero latency), and drive them to 0 otherwise.
REQ-022 SHALL leave XFER on the cycle usr_end[w] = 1, update the pointer to w, and spend one GAP cycle with gnt = 0.
REQ-023 SHALL return to IDLE at once, drive gnt = 0 and tx_req_vc0 = 0, and hold the pointer when dl_up falls in any state.
REQ-024 SHALL ignore req changes while a grant is active.

Reset
REQ-025 SHALL on rst_n low set: state IDLE, pointer = 1 (requester 0 wins the first tie), gnt = 0, tx_req_vc0 = 0, arb_timeout = 0, timeout counter = 0.

Configuration
REQ-026 SHALL, with PCIE_TX_ARB_TIMEOUT_EN defined, count cycles in REQ; at TOUT_CYC it drops tx_req_vc0, pulses arb_timeout, sets the pointer to w, and returns to IDLE.
REQ-027 SHALL, without PCIE_TX_ARB_TIMEOUT_EN, wait in REQ indefinitely and tie arb_timeout to 0.

Structure
REQ-028 SHALL place FSM state encodings, the req_type codes, and the infinite-credit bit position in shared package pcie_tx_pkg.
REQ-029 SHALL put the credit comparison (type select, infinite check, >= compare) in sub-module pcie_tx_cred_chk, instantiated once per requester.

Verification
REQ-030 SHALL cover: req = 01, type posted, dcred = 4, ph = 8, pd = 16, tx_rdy 3 cycles after tx_req -> gnt = 01 in the cycle after tx_rdy, data passed unchanged, GAP then IDLE.
REQ-031 SHALL cover: req = 11 held, both eligible, 4 back-to-back TLPs -> grant order 0, 1, 0, 1.
REQ-032 SHALL cover: req = 11, requester 0 non-posted with npd = 0 and dcred = 1, requester 1 completion with cpld = 0x1000 (infinite) -> requester 1 granted; requester 0 waits until npd >= 1.
REQ-033 SHALL cover: dl_up deasserted mid-XFER after 3 data beats -> next cycle gnt = 00, tx_req_vc0 = 0, state IDLE.
REQ-034 SHALL cover, with the macro, TOUT_CYC = 16 and tx_rdy held 0 -> arb_timeout pulses in cycle 16 of REQ, tx_req_vc0 drops, and the other requester is served next; without the macro, tx_req_vc0 stays high.
REQ-035 SHALL cover: rst_n asserted during REQ -> all outputs 0 asynchronously; after release, a tie grants requester 0.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIe VC0 TX arbiter: FSM encodings, TLP type
// codes, credit widths and infinite-credit bit positions, credit bundle.
package pcie_tx_pkg;

  localparam int unsigned ST_W        = 3;
  localparam int unsigned HCRED_W     = 9;
  localparam int unsigned DCRED_W     = 13;
  localparam int unsigned REQ_DCRED_W = 9;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_CHECK = 3'd1;
  localparam logic [ST_W-1:0] S_REQ   = 3'd2;
  localparam logic [ST_W-1:0] S_XFER  = 3'd3;
  localparam logic [ST_W-1:0] S_GAP   = 3'd4;

  localparam logic [1:0] TYPE_P    = 2'd0;
  localparam logic [1:0] TYPE_NP   = 2'd1;
  localparam logic [1:0] TYPE_CPL  = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  // A credit counter with its MSB set means unlimited credits.
  localparam int unsigned HCRED_INF_BIT = HCRED_W - 1;
  localparam int unsigned DCRED_INF_BIT = DCRED_W - 1;

  typedef struct packed {
    logic [HCRED_W-1:0] ph;
    logic [HCRED_W-1:0] nph;
    logic [HCRED_W-1:0] cplh;
    logic [DCRED_W-1:0] pd;
    logic [DCRED_W-1:0] npd;
    logic [DCRED_W-1:0] cpld;
  } cred_t;

endpackage

// File: rtl/pcie_tx_cred_chk.sv
// Per-requester eligibility: selects the credit pair for the TLP type and
// checks header and data credits, honouring the infinite-credit encoding.
module pcie_tx_cred_chk
  import pcie_tx_pkg::*;
(
  input  logic                   req,
  input  logic [1:0]             req_type,
  input  logic [REQ_DCRED_W-1:0] req_dcred,
  input  cred_t                  cred,
  output logic                   elig_c
);

  logic [HCRED_W-1:0] hcred;
  logic [DCRED_W-1:0] dcred;
  logic               type_ok;
  logic               h_ok;
  logic               d_ok;

  // Credit selection by type and the two sufficiency compares.
  always_comb begin
    hcred   = '0;
    dcred   = '0;
    type_ok = 1'b1;
    case (req_type)
      TYPE_P:   begin hcred = cred.ph;   dcred = cred.pd;   end
      TYPE_NP:  begin hcred = cred.nph;  dcred = cred.npd;  end
      TYPE_CPL: begin hcred = cred.cplh; dcred = cred.cpld; end
      default:  type_ok = 1'b0;
    endcase
    h_ok   = hcred[HCRED_INF_BIT] | (hcred >= HCRED_W'(1));
    d_ok   = dcred[DCRED_INF_BIT] | (dcred >= DCRED_W'(req_dcred));
    elig_c = req & type_ok & h_ok & d_ok;
  end

endmodule

// File: rtl/pcie_tx_arb.sv
// Two-requester round-robin arbiter in front of the PCIe core VC0 TX port.
// Optional REQ-phase timeout is built when PCIE_TX_ARB_TIMEOUT_EN is defined.
module pcie_tx_arb
  import pcie_tx_pkg::*;
#(
  parameter int unsigned TOUT_CYC = 4096
)
(
  input  logic                sys_clk_125,
  input  logic                rst_n,
  input  logic                dl_up,
  input  logic [1:0]          req,
  input  logic [3:0]          req_type,
  input  logic [17:0]         req_dcred,
  output logic [1:0]          gnt,
  input  logic [31:0]         usr_data,
  input  logic [1:0]          usr_st,
  input  logic [1:0]          usr_end,
  output logic                tx_req_vc0,
  output logic [15:0]         tx_data_vc0,
  output logic                tx_st_vc0,
  output logic                tx_end_vc0,
  input  logic                tx_rdy_vc0,
  input  logic [HCRED_W-1:0]  tx_ca_ph_vc0,
  input  logic [HCRED_W-1:0]  tx_ca_nph_vc0,
  input  logic [HCRED_W-1:0]  tx_ca_cplh_vc0,
  input  logic [DCRED_W-1:0]  tx_ca_pd_vc0,
  input  logic [DCRED_W-1:0]  tx_ca_npd_vc0,
  input  logic [DCRED_W-1:0]  tx_ca_cpld_vc0,
  output logic                arb_timeout
);

  localparam int unsigned CNT_W = $clog2(TOUT_CYC + 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic             win_q, win_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             tx_req_q, tx_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_d;
  logic [1:0]       elig_c;
  cred_t            cred;

  // Bundle the core's available credits for the checkers.
  always_comb begin
    cred = '{ph: tx_ca_ph_vc0, nph: tx_ca_nph_vc0, cplh: tx_ca_cplh_vc0,
             pd: tx_ca_pd_vc0, npd: tx_ca_npd_vc0, cpld: tx_ca_cpld_vc0};
  end

  for (genvar n = 0; n < 2; n++) begin : g_chk
    pcie_tx_cred_chk u_chk (
      .req       (req[n]),
      .req_type  (req_type[2*n +: 2]),
      .req_dcred (req_dcred[REQ_DCRED_W*n +: REQ_DCRED_W]),
      .cred      (cred),
      .elig_c    (elig_c[n])
    );
  end

  // Arbitration FSM next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    tx_req_d = tx_req_q;
    cnt_d    = '0;
    tout_d   = 1'b0;
    if (!dl_up) begin
      state_d  = S_IDLE;
      gnt_d    = '0;
      tx_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig_c) begin
            // Tie goes to the requester that was not granted last.
            win_d   = (&elig_c) ? ~ptr_q : elig_c[1];
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (elig_c[win_q]) begin
            state_d  = S_REQ;
            tx_req_d = 1'b1;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_REQ: begin
          cnt_d = (cnt_q == CNT_W'(TOUT_CYC)) ? cnt_q : cnt_q + CNT_W'(1);
          if (tx_rdy_vc0) begin
            state_d  = S_XFER;
            tx_req_d = 1'b0;
            gnt_d    = win_q ? 2'b10 : 2'b01;
          end
`ifdef PCIE_TX_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TOUT_CYC - 1)) begin
            state_d  = S_IDLE;
            tx_req_d = 1'b0;
            tout_d   = 1'b1;
            ptr_d    = win_q;
          end
`endif
        end
        S_XFER: begin
          if (usr_end[win_q]) begin
            state_d = S_GAP;
            gnt_d   = '0;
            ptr_d   = win_q;
          end
        end
        S_GAP:   state_d = S_IDLE;
        default: begin
          state_d  = S_IDLE;
          gnt_d    = '0;
          tx_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      ptr_q    <= 1'b1;
      gnt_q    <= '0;
      tx_req_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      tx_req_q <= tx_req_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef PCIE_TX_ARB_TIMEOUT_EN
  logic tout_q;

  // One-cycle timeout pulse register.
  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) tout_q <= 1'b0;
    else        tout_q <= tout_d;
  end

  assign arb_timeout = tout_q;
`else
  assign arb_timeout = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign tx_req_vc0 = tx_req_q;

  // Zero-latency data path from the winner while transferring.
  always_comb begin
    tx_data_vc0 = '0;
    tx_st_vc0   = 1'b0;
    tx_end_vc0  = 1'b0;
    if (state_q == S_XFER) begin
      tx_data_vc0 = win_q ? usr_data[31:16] : usr_data[15:0];
      tx_st_vc0   = usr_st[win_q];
      tx_end_vc0  = usr_end[win_q];
    end
  end

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Bench for pcie_tx_arb: directed scenarios plus randomized arbitration
// rounds checked against a transaction-level round-robin/credit model.
module tb_pcie_tx_arb;

  logic        sys_clk_125 = 1'b0;
  logic        rst_n, dl_up, tx_rdy_vc0;
  logic [1:0]  req, usr_st, usr_end, gnt;
  logic [3:0]  req_type;
  logic [17:0] req_dcred;
  logic [31:0] usr_data;
  logic        tx_req_vc0, tx_st_vc0, tx_end_vc0, arb_timeout;
  logic [15:0] tx_data_vc0;
  logic [8:0]  tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0;
  logic [12:0] tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0;

  int n_chk  = 0;
  int n_fail = 0;
  int last_w = 1;

  always #4 sys_clk_125 = ~sys_clk_125;

  pcie_tx_arb #(.TOUT_CYC(16)) dut (
    .sys_clk_125(sys_clk_125), .rst_n(rst_n), .dl_up(dl_up),
    .req(req), .req_type(req_type), .req_dcred(req_dcred), .gnt(gnt),
    .usr_data(usr_data), .usr_st(usr_st), .usr_end(usr_end),
    .tx_req_vc0(tx_req_vc0), .tx_data_vc0(tx_data_vc0), .tx_st_vc0(tx_st_vc0),
    .tx_end_vc0(tx_end_vc0), .tx_rdy_vc0(tx_rdy_vc0),
    .tx_ca_ph_vc0(tx_ca_ph_vc0), .tx_ca_nph_vc0(tx_ca_nph_vc0),
    .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_pd_vc0(tx_ca_pd_vc0),
    .tx_ca_npd_vc0(tx_ca_npd_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
    .arb_timeout(arb_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_125);
    #1;
  endtask

  // Model: requester n may send if it asks, has a legal type, at least one
  // header credit, and enough data credit. Infinite values (MSB set) are
  // numerically larger than any demand, so plain compares cover them.
  function automatic bit m_elig(input int n);
    int t, need, hc, dc;
    t    = int'(req_type >> (2 * n)) & 3;
    need = int'(req_dcred >> (9 * n)) & 511;
    case (t)
      0: begin hc = int'(tx_ca_ph_vc0);   dc = int'(tx_ca_pd_vc0);   end
      1: begin hc = int'(tx_ca_nph_vc0);  dc = int'(tx_ca_npd_vc0);  end
      2: begin hc = int'(tx_ca_cplh_vc0); dc = int'(tx_ca_cpld_vc0); end
      default: return 1'b0;
    endcase
    return (req[n] == 1'b1) && (hc >= 1) && (dc >= need);
  endfunction

  // Model: winner index, or -1 when nobody is eligible.
  function automatic int m_pick();
    bit e0, e1;
    e0 = m_elig(0);
    e1 = m_elig(1);
    if (e0 && e1) return (last_w == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic logic [8:0] rnd_h();
    return ($urandom_range(0, 5) == 0) ? 9'(9'h100 | 9'($urandom_range(0, 255)))
                                       : 9'($urandom_range(0, 2));
  endfunction

  function automatic logic [12:0] rnd_d();
    return ($urandom_range(0, 5) == 0) ? 13'(13'h1000 | 13'($urandom_range(0, 4095)))
                                       : 13'($urandom_range(0, 6));
  endfunction

  task automatic cred_ok();
    tx_ca_ph_vc0 = 9'd8;  tx_ca_nph_vc0 = 9'd8;  tx_ca_cplh_vc0 = 9'd8;
    tx_ca_pd_vc0 = 13'd16; tx_ca_npd_vc0 = 13'd16; tx_ca_cpld_vc0 = 13'd16;
  endtask

  task automatic wait_txreq(input string tag);
    int k;
    k = 0;
    while (tx_req_vc0 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(tx_req_vc0), 32'd1);
  endtask

  task automatic grant_wait(input int w, input int dly);
    logic [1:0] oh;
    oh = (w == 1) ? 2'b10 : 2'b01;
    check("req_gnt_low", 32'(gnt), 32'd0);
    repeat (dly) tick();
    tx_rdy_vc0 = 1'b1;
    tick();
    tx_rdy_vc0 = 1'b0;
    check("xfer_gnt", 32'(gnt), 32'(oh));
    check("xfer_txreq_low", 32'(tx_req_vc0), 32'd0);
  endtask

  task automatic beat(input int w, input bit first, input bit fin);
    logic [31:0] d;
    logic [15:0] exp_d;
    logic [1:0]  oh;
    d     = $urandom;
    oh    = (w == 1) ? 2'b10 : 2'b01;
    exp_d = (w == 1) ? d[31:16] : d[15:0];
    usr_data = d;
    usr_st   = first ? oh : 2'b00;
    usr_end  = fin ? oh : 2'b00;
    #1;
    check("beat_data", 32'(tx_data_vc0), 32'(exp_d));
    check("beat_st", 32'(tx_st_vc0), 32'(first));
    check("beat_end", 32'(tx_end_vc0), 32'(fin));
    check("beat_gnt", 32'(gnt), 32'(oh));
    tick();
    usr_st  = 2'b00;
    usr_end = 2'b00;
  endtask

  task automatic serve(input int w, input int dly, input int beats);
    grant_wait(w, dly);
    for (int b = 0; b < beats; b++) beat(w, b == 0, b == beats - 1);
    check("gap_gnt", 32'(gnt), 32'd0);
    check("gap_txreq", 32'(tx_req_vc0), 32'd0);
    check("gap_data", 32'(tx_data_vc0), 32'd0);
    last_w = w;
  endtask

  initial begin
    int ord[4];
    int e, w;
    ord = '{0, 1, 0, 1};
    rst_n = 1'b0; dl_up = 1'b1; tx_rdy_vc0 = 1'b0;
    req = 2'b00; req_type = 4'h0; req_dcred = '0;
    usr_data = '0; usr_st = 2'b00; usr_end = 2'b00;
    cred_ok();
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_txreq", 32'(tx_req_vc0), 32'd0);
    check("rst_tout", 32'(arb_timeout), 32'd0);
    check("rst_data", 32'(tx_data_vc0), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Both held and eligible: strict alternation starting with requester 0.
    req = 2'b11; req_dcred = {9'd4, 9'd4};
    for (int i = 0; i < 4; i++) begin
      wait_txreq("rr_req");
      serve(ord[i], 1, 2);
    end

    // Non-posted starved of data credit; infinite completion credit wins.
    req = 2'b11; req_type = {2'd2, 2'd1}; req_dcred = {9'd0, 9'd1};
    tx_ca_npd_vc0 = 13'd0; tx_ca_cpld_vc0 = 13'h1000;
    wait_txreq("bypass_req");
    serve(1, 1, 2);
    req = 2'b01;
    repeat (6) tick();
    check("np_blocked", 32'(tx_req_vc0), 32'd0);
    tx_ca_npd_vc0 = 13'd1;
    wait_txreq("np_unblock_req");
    serve(0, 0, 1);

    // Single posted TLP, ready three cycles after the request.
    req = 2'b01; req_type = 4'h0; req_dcred = {9'd0, 9'd4};
    cred_ok(); tx_ca_ph_vc0 = 9'd8; tx_ca_pd_vc0 = 13'd16;
    wait_txreq("basic_req");
    serve(0, 3, 3);
    req = 2'b00;
    tick(); tick();
    check("idle_txreq", 32'(tx_req_vc0), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);

    // Link drop after three data beats aborts the transfer.
    req = 2'b01;
    wait_txreq("dl_req");
    grant_wait(0, 1);
    beat(0, 1'b1, 1'b0); beat(0, 1'b0, 1'b0); beat(0, 1'b0, 1'b0);
    dl_up = 1'b0; usr_data = 32'hA5A5_5A5A; usr_st = 2'b01;
    tick();
    check("dl_gnt", 32'(gnt), 32'd0);
    check("dl_txreq", 32'(tx_req_vc0), 32'd0);
    check("dl_st", 32'(tx_st_vc0), 32'd0);
    check("dl_data", 32'(tx_data_vc0), 32'd0);
    usr_st = 2'b00;
    tick();
    dl_up = 1'b1; req = 2'b00;
    tick();

    // Core never ready.
    req = 2'b11; req_dcred = '0; cred_ok();
    w = m_pick();
    wait_txreq("tout_req");
`ifdef PCIE_TX_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      check("tout_hold", 32'(tx_req_vc0), 32'd1);
      check("tout_quiet", 32'(arb_timeout), 32'd0);
      tick();
    end
    check("tout_hold16", 32'(tx_req_vc0), 32'd1);
    tick();
    check("tout_pulse", 32'(arb_timeout), 32'd1);
    check("tout_txreq", 32'(tx_req_vc0), 32'd0);
    check("tout_gnt", 32'(gnt), 32'd0);
    last_w = w;
    tick();
    check("tout_pulse_end", 32'(arb_timeout), 32'd0);
    wait_txreq("tout_next_req");
    serve(1 - w, 0, 1);
`else
    repeat (40) tick();
    check("notout_hold", 32'(tx_req_vc0), 32'd1);
    check("notout_quiet", 32'(arb_timeout), 32'd0);
    serve(w, 0, 1);
`endif

    // Randomized rounds against the model.
    for (int it = 0; it < 40; it++) begin
      req       = 2'($urandom_range(0, 3));
      req_type  = 4'($urandom);
      req_dcred = {9'($urandom_range(0, 6)), 9'($urandom_range(0, 6))};
      tx_ca_ph_vc0 = rnd_h(); tx_ca_nph_vc0 = rnd_h(); tx_ca_cplh_vc0 = rnd_h();
      tx_ca_pd_vc0 = rnd_d(); tx_ca_npd_vc0 = rnd_d(); tx_ca_cpld_vc0 = rnd_d();
      e = m_pick();
      if (e < 0) begin
        repeat (5) tick();
        check("rnd_idle_txreq", 32'(tx_req_vc0), 32'd0);
        check("rnd_idle_gnt", 32'(gnt), 32'd0);
      end else begin
        wait_txreq("rnd_req");
        serve(e, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      end
    end

    // Asynchronous reset while requesting, then a tie after release.
    req = 2'b01; req_type = 4'h0; req_dcred = '0; cred_ok();
    wait_txreq("rst_req");
    rst_n = 1'b0;
    #1;
    check("arst_txreq", 32'(tx_req_vc0), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_tout", 32'(arb_timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    last_w = 1;
    req = 2'b11;
    wait_txreq("post_rst_req");
    serve(0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
